vx_credit_sender: RTL and testbench
===================================

# vx_credit_sender

Credit-based producer that drives the push side of a remote fixed-depth FIFO across a pipeline boundary. Tracks free remote entries with a local counter initialised to the remote depth, debits one credit per push and credits one back per remote pop pulse, so the remote queue can never overflow. Sits at the sender end of any link whose receiver is a power-of-2 FIFO (e.g. core-to-cache request paths, memory response return).

## Interface
- DATAW, 1, payload width
- SIZE, 2, remote FIFO depth; power of 2, ≥1
- ALM_LOW, 1, alm_no_credit asserted when credits ≤ ALM_LOW; 0 ≤ ALM_LOW < SIZE
- OUT_REG, 0, 0 = combinational push/push_data; 1 = registered output stage
- CREDITW, $clog2(SIZE+1), credit counter width

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream payload valid
- in_data  in  DATAW  upstream payload
- in_ready  out  1  sender accepts payload this cycle
- push  out  1  write strobe to remote FIFO
- push_data  out  DATAW  data to remote FIFO
- credit_in  in  1  one-cycle pulse per remote pop
- credits  out  CREDITW  free remote entries
- no_credit  out  1  credits == 0
- alm_no_credit  out  1  credits ≤ ALM_LOW
- idle  out  1  credits == SIZE (all remote entries drained, no push in flight)
- err  out  1  sticky: credit_in while credits == SIZE

## Operation
- Accept = in_valid && in_ready; in_ready = !no_credit && !reset.
- Counter update each cycle: credits += credit_in − accept; both asserted → unchanged. Arithmetic in CREDITW bits, signed 2-bit delta as in the team's FIFO used-count.
- credit_in while credits == SIZE and no accept: counter holds at SIZE, err set; cleared only by reset.
- Flags no_credit, alm_no_credit, idle are registers updated with the counter by equality compares against current value and delta (credits == 1 && accept && !credit_in → no_credit next, etc.); never derived combinationally from credits.
- OUT_REG=0: push = accept, push_data = in_data.
- OUT_REG=1: push_r <= accept, push_data_r <= in_data when accept; push_data holds otherwise. Credit debited at accept, not at push.
- idle with OUT_REG=1 additionally requires push_r == 0.
- SIZE == 1: counter degenerates to single bit; no_credit = !credits, alm_no_credit = 1.

## Timing
- Reset values: credits = SIZE, no_credit = 0, alm_no_credit = (SIZE ≤ ALM_LOW ? 1 : 0), idle = 1, err = 0, push = 0, in_ready = 0; push_data undefined until first accept.
- Reset mid-operation: in-flight registered push dropped; counter restored to SIZE next edge regardless of credit_in.
- OUT_REG=0 latency: push same cycle as accept; credits/flags reflect accept one cycle later.
- OUT_REG=1 latency: push one cycle after accept.
- Credit return latency: credit_in at cycle N → in_ready may rise in cycle N+1.
- Back-to-back: with credits ≥ 1 and credit_in every cycle, one push per cycle sustained indefinitely.

## Structure
- No shared package types; CREDITW, flag thresholds are local parameters.
- No sub-module; counter, flags and optional output register inline, split by OUT_REG generate branch.
- Runtime assertions: !(push && credits_seen_zero); err rising reported.

## Test plan
- SIZE=4, in_valid held, no credit_in → exactly 4 pushes on cycles 0–3, in_ready low from cycle 4, no_credit=1, credits=0.
- From credits=0, single credit_in pulse at cycle N → in_ready=1 cycle N+1, one push, credits back to 0.
- credits=2, accept and credit_in same cycle for 10 cycles → credits stays 2, 10 pushes, flags unchanged.
- ALM_LOW=1, SIZE=4: pushes from 4 → alm_no_credit rises when credits becomes 1, falls on return to 2.
- idle state, extra credit_in → credits stays 4, err=1 and stays 1 until reset.
- OUT_REG=1, accept data 0xA5 cycle 0 → push=1, push_data=0xA5 cycle 1; reset asserted cycle 1 → credits=4, push=0 cycle 2.

Source files
------------

// File: rtl/vx_credit_sender_pkg.sv
// -----------------------------------------------------------------------------
// vx_credit_sender_pkg
//   Shared helpers for the credit sender. Holds the signed credit-delta
//   encoding used by the credit counter, which is the same +1/0/-1 encoding
//   used by the team FIFO used-count logic.
// -----------------------------------------------------------------------------
package vx_credit_sender_pkg;

  // Two-bit signed delta: +1 for a returned credit, -1 for a debit, 0 otherwise.
  // Callers guarantee inc and dec are never both set.
  function automatic logic signed [1:0] credit_delta(input logic inc, input logic dec);
    logic signed [1:0] d;
    if (inc) begin
      d = 2'sb01;
    end else if (dec) begin
      d = 2'sb11;
    end else begin
      d = 2'sb00;
    end
    return d;
  endfunction

endpackage

// File: rtl/vx_credit_sender_chk.sv
// -----------------------------------------------------------------------------
// vx_credit_sender_chk
//   Runtime checks for vx_credit_sender.
//   - A push must never be issued against a credit count that was zero when the
//     payload was accepted (same cycle for OUT_REG=0, previous cycle for
//     OUT_REG=1).
//   - The rise of the sticky err flag is covered so it shows in coverage.
// Ports: clk, reset (sync, active-high), in_valid/in_ready (accept handshake),
//   push, credits, err -- all observed, none driven.
// -----------------------------------------------------------------------------
module vx_credit_sender_chk #(
  parameter int OUT_REG = 0,
  parameter int CREDITW = 2
) (
  input logic               clk,
  input logic               reset,
  input logic               in_valid,
  input logic               in_ready,
  input logic               push,
  input logic [CREDITW-1:0] credits,
  input logic               err
);

  logic zero_at_accept_r;
  logic seen_zero;

  // Remembers whether the previous accept happened with no credits left.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_at_accept_r <= 1'b0;
    end else begin
      zero_at_accept_r <= in_valid && in_ready && (credits == {CREDITW{1'b0}});
    end
  end

  assign seen_zero = (OUT_REG != 0) ? zero_at_accept_r : (credits == {CREDITW{1'b0}});

  a_no_push_without_credit: assert property (@(posedge clk) disable iff (reset) !(push && seen_zero));

  c_err_rise: cover property (@(posedge clk) disable iff (reset) $rose(err));

endmodule

// File: rtl/vx_credit_sender.sv
// -----------------------------------------------------------------------------
// vx_credit_sender
//   Credit-based producer for the push side of a remote fixed-depth FIFO.
//   A local counter starts at the remote depth, is debited on every accepted
//   payload and credited on every remote pop pulse, so the remote queue can
//   never overflow.
// Parameters: DATAW payload width, SIZE remote depth (power of 2, >=1),
//   ALM_LOW almost-empty threshold, OUT_REG 0=combinational push / 1=registered,
//   CREDITW counter width.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_data    upstream payload, in_ready = accept possible
//   push/push_data      write strobe and data towards the remote FIFO
//   credit_in           one-cycle pulse per remote pop
//   credits             free remote entries
//   no_credit           credits == 0
//   alm_no_credit       credits <= ALM_LOW
//   idle                all credits home and no push in flight
//   err                 sticky: credit returned while already full
// -----------------------------------------------------------------------------
module vx_credit_sender
  import vx_credit_sender_pkg::*;
#(
  parameter int DATAW   = 1,
  parameter int SIZE    = 2,
  parameter int ALM_LOW = 1,
  parameter int OUT_REG = 0,
  parameter int CREDITW = $clog2(SIZE + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [DATAW-1:0]   in_data,
  output logic               in_ready,
  output logic               push,
  output logic [DATAW-1:0]   push_data,
  input  logic               credit_in,
  output logic [CREDITW-1:0] credits,
  output logic               no_credit,
  output logic               alm_no_credit,
  output logic               idle,
  output logic               err
);

  localparam logic [CREDITW-1:0] FULL_CNT   = CREDITW'(SIZE);
  localparam logic [CREDITW-1:0] ONE_CNT    = CREDITW'(1);
  localparam logic [CREDITW-1:0] ALM_CNT    = CREDITW'(ALM_LOW);
  // A debit from this value or below lands at or under the alarm threshold.
  localparam logic [CREDITW-1:0] ALM_HI_CNT = CREDITW'(ALM_LOW + 1);
  // A single-entry remote FIFO is always "almost out of credit".
  localparam logic               ALM_RST    = (SIZE <= ALM_LOW) || (SIZE == 1);

  logic [CREDITW-1:0] credits_r, credits_next;
  logic               no_credit_r, no_credit_next;
  logic               alm_r, alm_next;
  logic               full_r, full_next;
  logic               idle_r, idle_next;
  logic               err_r, err_next;
  logic               accept, at_full, inc, dec;
  logic signed [1:0]  delta;

  assign in_ready = !no_credit_r && !reset;

  // Next-state of the counter and its flags; flags are predicted from the
  // current count and the delta so they can be registered alongside it.
  always_comb begin
    accept  = in_valid && in_ready;
    at_full = (credits_r == FULL_CNT);
    // A credit arriving at full is discarded (and flagged) rather than wrapping.
    inc     = credit_in && !accept && !at_full;
    dec     = accept && !credit_in;
    delta   = credit_delta(inc, dec);
    credits_next   = credits_r + CREDITW'(delta);
    no_credit_next = no_credit_r;
    alm_next       = alm_r;
    full_next      = full_r;
    if (dec) begin
      no_credit_next = (credits_r == ONE_CNT);
      alm_next       = (credits_r <= ALM_HI_CNT);
      full_next      = 1'b0;
    end else if (inc) begin
      no_credit_next = 1'b0;
      alm_next       = (credits_r < ALM_CNT);
      full_next      = (credits_r == (FULL_CNT - ONE_CNT));
    end else begin
      no_credit_next = no_credit_r;
    end
    if (SIZE == 1) begin
      alm_next = 1'b1;
    end else begin
      alm_next = alm_next;
    end
    // With a registered output an accept leaves a push in flight next cycle.
    idle_next = full_next && !((OUT_REG != 0) && accept);
    err_next  = err_r || (credit_in && at_full);
  end

  // Credit counter and status flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_r   <= FULL_CNT;
      no_credit_r <= 1'b0;
      alm_r       <= ALM_RST;
      full_r      <= 1'b1;
      idle_r      <= 1'b1;
      err_r       <= 1'b0;
    end else begin
      credits_r   <= credits_next;
      no_credit_r <= no_credit_next;
      alm_r       <= alm_next;
      full_r      <= full_next;
      idle_r      <= idle_next;
      err_r       <= err_next;
    end
  end

  assign credits       = credits_r;
  assign no_credit     = no_credit_r;
  assign alm_no_credit = alm_r;
  assign idle          = idle_r;
  assign err           = err_r;

  generate
    if (OUT_REG != 0) begin : gen_out_reg
      logic             push_r;
      logic [DATAW-1:0] push_data_r;

      // Output stage: strobe follows accept by one cycle; data holds between pushes.
      always_ff @(posedge clk) begin
        if (reset) begin
          push_r <= 1'b0;
        end else begin
          push_r <= accept;
        end
        if (accept) begin
          push_data_r <= in_data;
        end else begin
          push_data_r <= push_data_r;
        end
      end

      assign push      = push_r;
      assign push_data = push_data_r;
    end else begin : gen_out_comb
      assign push      = accept;
      assign push_data = in_data;
    end
  endgenerate

  vx_credit_sender_chk #(
    .OUT_REG (OUT_REG),
    .CREDITW (CREDITW)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .push     (push),
    .credits  (credits_r),
    .err      (err_r)
  );

endmodule

// File: tb/tb_vx_credit_sender.sv
// -----------------------------------------------------------------------------
// tb_vx_credit_sender
//   Directed bench for vx_credit_sender. Instance u_dut0 uses SIZE=4,
//   ALM_LOW=1, OUT_REG=0; instance u_dut1 uses the same sizing with OUT_REG=1.
//   Inputs change 1 time unit after the rising edge and outputs are sampled
//   2 units after it.
// -----------------------------------------------------------------------------
module tb_vx_credit_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset0, in_valid0, in_ready0, push0, credit_in0;
  logic       no_credit0, alm0, idle0, err0;
  logic [7:0] in_data0, push_data0;
  logic [2:0] credits0;

  logic       reset1, in_valid1, in_ready1, push1, credit_in1;
  logic       no_credit1, alm1, idle1, err1;
  logic [7:0] in_data1, push_data1;
  logic [2:0] credits1;

  int checks = 0;
  int passes = 0;
  int pushes0 = 0;

  vx_credit_sender #(.DATAW(8), .SIZE(4), .ALM_LOW(1), .OUT_REG(0)) u_dut0 (
    .clk(clk), .reset(reset0), .in_valid(in_valid0), .in_data(in_data0),
    .in_ready(in_ready0), .push(push0), .push_data(push_data0),
    .credit_in(credit_in0), .credits(credits0), .no_credit(no_credit0),
    .alm_no_credit(alm0), .idle(idle0), .err(err0)
  );

  vx_credit_sender #(.DATAW(8), .SIZE(4), .ALM_LOW(1), .OUT_REG(1)) u_dut1 (
    .clk(clk), .reset(reset1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .push(push1), .push_data(push_data1),
    .credit_in(credit_in1), .credits(credits1), .no_credit(no_credit1),
    .alm_no_credit(alm1), .idle(idle1), .err(err1)
  );

  // Push counter for u_dut0, sampled mid-cycle.
  always @(negedge clk) if (push0 === 1'b1) pushes0 = pushes0 + 1;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset0 = 1'b1; in_valid0 = 1'b0; in_data0 = 8'h00; credit_in0 = 1'b0;
    reset1 = 1'b1; in_valid1 = 1'b0; in_data1 = 8'h00; credit_in1 = 1'b0;
    cycle(); cycle(); #1;
    checks++; if (credits0 !== 3'd4) $display("FAIL reset_credits0: got %0d expected 4", credits0); else passes++;
    checks++; if (no_credit0 !== 1'b0) $display("FAIL reset_no_credit0: got %b expected 0", no_credit0); else passes++;
    checks++; if (alm0 !== 1'b0) $display("FAIL reset_alm0: got %b expected 0", alm0); else passes++;
    checks++; if (idle0 !== 1'b1) $display("FAIL reset_idle0: got %b expected 1", idle0); else passes++;
    checks++; if (err0 !== 1'b0) $display("FAIL reset_err0: got %b expected 0", err0); else passes++;
    checks++; if (push0 !== 1'b0) $display("FAIL reset_push0: got %b expected 0", push0); else passes++;
    checks++; if (in_ready0 !== 1'b0) $display("FAIL reset_in_ready0: got %b expected 0", in_ready0); else passes++;
    checks++; if (credits1 !== 3'd4) $display("FAIL reset_credits1: got %0d expected 4", credits1); else passes++;
    checks++; if (push1 !== 1'b0) $display("FAIL reset_push1: got %b expected 0", push1); else passes++;
    checks++; if (idle1 !== 1'b1) $display("FAIL reset_idle1: got %b expected 1", idle1); else passes++;
    reset0 = 1'b0; reset1 = 1'b0;
  endtask

  task automatic test_fill();
    cycle();
    pushes0 = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cycle();
      in_valid0 = 1'b1;
      in_data0 = 8'h10 + 8'(k);
      #1;
      checks++; if (in_ready0 !== 1'b1) $display("FAIL fill_in_ready k=%0d: got %b expected 1", k, in_ready0); else passes++;
      checks++; if (push0 !== 1'b1) $display("FAIL fill_push k=%0d: got %b expected 1", k, push0); else passes++;
      checks++; if (push_data0 !== (8'h10 + 8'(k))) $display("FAIL fill_data k=%0d: got %h expected %h", k, push_data0, 8'h10 + 8'(k)); else passes++;
      checks++; if (credits0 !== 3'(4 - k)) $display("FAIL fill_credits k=%0d: got %0d expected %0d", k, credits0, 4 - k); else passes++;
      checks++; if (alm0 !== ((4 - k) <= 1)) $display("FAIL fill_alm k=%0d: got %b expected %b", k, alm0, (4 - k) <= 1); else passes++;
    end
    cycle(); #1;
    checks++; if (in_ready0 !== 1'b0) $display("FAIL empty_in_ready: got %b expected 0", in_ready0); else passes++;
    checks++; if (push0 !== 1'b0) $display("FAIL empty_push: got %b expected 0", push0); else passes++;
    checks++; if (credits0 !== 3'd0) $display("FAIL empty_credits: got %0d expected 0", credits0); else passes++;
    checks++; if (no_credit0 !== 1'b1) $display("FAIL empty_no_credit: got %b expected 1", no_credit0); else passes++;
    checks++; if (alm0 !== 1'b1) $display("FAIL empty_alm: got %b expected 1", alm0); else passes++;
    checks++; if (idle0 !== 1'b0) $display("FAIL empty_idle: got %b expected 0", idle0); else passes++;
    checks++; if (pushes0 != 4) $display("FAIL fill_push_count: got %0d expected 4", pushes0); else passes++;
  endtask

  task automatic test_credit_return();
    cycle();
    pushes0 = 0;
    credit_in0 = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b0) $display("FAIL ret_in_ready_same: got %b expected 0", in_ready0); else passes++;
    cycle();
    credit_in0 = 1'b0;
    #1;
    checks++; if (credits0 !== 3'd1) $display("FAIL ret_credits: got %0d expected 1", credits0); else passes++;
    checks++; if (in_ready0 !== 1'b1) $display("FAIL ret_in_ready: got %b expected 1", in_ready0); else passes++;
    checks++; if (push0 !== 1'b1) $display("FAIL ret_push: got %b expected 1", push0); else passes++;
    cycle(); #1;
    checks++; if (credits0 !== 3'd0) $display("FAIL ret_credits_after: got %0d expected 0", credits0); else passes++;
    checks++; if (no_credit0 !== 1'b1) $display("FAIL ret_no_credit: got %b expected 1", no_credit0); else passes++;
    checks++; if (in_ready0 !== 1'b0) $display("FAIL ret_in_ready_after: got %b expected 0", in_ready0); else passes++;
    checks++; if (pushes0 != 1) $display("FAIL ret_push_count: got %0d expected 1", pushes0); else passes++;
    in_valid0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    cycle(); credit_in0 = 1'b1;
    cycle();
    cycle();
    in_valid0 = 1'b1;
    pushes0 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cycle();
      in_data0 = 8'h40 + 8'(i);
      #1;
      checks++; if (credits0 !== 3'd2) $display("FAIL b2b_credits i=%0d: got %0d expected 2", i, credits0); else passes++;
      checks++; if (push0 !== 1'b1) $display("FAIL b2b_push i=%0d: got %b expected 1", i, push0); else passes++;
      checks++; if (push_data0 !== (8'h40 + 8'(i))) $display("FAIL b2b_data i=%0d: got %h expected %h", i, push_data0, 8'h40 + 8'(i)); else passes++;
      checks++; if ({no_credit0, alm0, idle0} !== 3'b000) $display("FAIL b2b_flags i=%0d: got %b expected 000", i, {no_credit0, alm0, idle0}); else passes++;
    end
    cycle();
    in_valid0 = 1'b0; credit_in0 = 1'b0;
    #1;
    checks++; if (credits0 !== 3'd2) $display("FAIL b2b_credits_end: got %0d expected 2", credits0); else passes++;
    checks++; if (pushes0 != 10) $display("FAIL b2b_push_count: got %0d expected 10", pushes0); else passes++;
  endtask

  task automatic test_alm();
    cycle(); credit_in0 = 1'b1;
    cycle();
    cycle(); credit_in0 = 1'b0;
    #1;
    checks++; if (credits0 !== 3'd4) $display("FAIL alm_refill: got %0d expected 4", credits0); else passes++;
    checks++; if (idle0 !== 1'b1) $display("FAIL alm_refill_idle: got %b expected 1", idle0); else passes++;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cycle();
      in_valid0 = 1'b1;
      #1;
      checks++; if (alm0 !== 1'b0) $display("FAIL alm_low_early i=%0d: got %b expected 0", i, alm0); else passes++;
    end
    cycle(); in_valid0 = 1'b0; #1;
    checks++; if (credits0 !== 3'd1) $display("FAIL alm_credits1: got %0d expected 1", credits0); else passes++;
    checks++; if (alm0 !== 1'b1) $display("FAIL alm_rise: got %b expected 1", alm0); else passes++;
    cycle(); credit_in0 = 1'b1;
    cycle(); credit_in0 = 1'b0; #1;
    checks++; if (credits0 !== 3'd2) $display("FAIL alm_credits2: got %0d expected 2", credits0); else passes++;
    checks++; if (alm0 !== 1'b0) $display("FAIL alm_fall: got %b expected 0", alm0); else passes++;
    cycle(); credit_in0 = 1'b1;
    cycle();
    cycle(); credit_in0 = 1'b0; #1;
    checks++; if (credits0 !== 3'd4) $display("FAIL alm_back_full: got %0d expected 4", credits0); else passes++;
    checks++; if (idle0 !== 1'b1) $display("FAIL alm_back_idle: got %b expected 1", idle0); else passes++;
  endtask

  task automatic test_err();
    cycle(); credit_in0 = 1'b1; #1;
    checks++; if (err0 !== 1'b0) $display("FAIL err_early: got %b expected 0", err0); else passes++;
    cycle(); credit_in0 = 1'b0; #1;
    checks++; if (credits0 !== 3'd4) $display("FAIL err_credits_hold: got %0d expected 4", credits0); else passes++;
    checks++; if (err0 !== 1'b1) $display("FAIL err_set: got %b expected 1", err0); else passes++;
    checks++; if (idle0 !== 1'b1) $display("FAIL err_idle: got %b expected 1", idle0); else passes++;
    for (int i = 0; i < 3; i++) begin
      cycle(); #1;
      checks++; if (err0 !== 1'b1) $display("FAIL err_sticky i=%0d: got %b expected 1", i, err0); else passes++;
    end
    reset0 = 1'b1;
    cycle(); #1;
    checks++; if (err0 !== 1'b0) $display("FAIL err_cleared: got %b expected 0", err0); else passes++;
    checks++; if (credits0 !== 3'd4) $display("FAIL err_reset_credits: got %0d expected 4", credits0); else passes++;
    reset0 = 1'b0;
  endtask

  task automatic test_out_reg();
    cycle();
    in_valid1 = 1'b1; in_data1 = 8'hA5; #1;
    checks++; if (in_ready1 !== 1'b1) $display("FAIL oreg_in_ready: got %b expected 1", in_ready1); else passes++;
    checks++; if (push1 !== 1'b0) $display("FAIL oreg_push_c0: got %b expected 0", push1); else passes++;
    cycle();
    in_valid1 = 1'b0; reset1 = 1'b1; credit_in1 = 1'b1; #1;
    checks++; if (push1 !== 1'b1) $display("FAIL oreg_push_c1: got %b expected 1", push1); else passes++;
    checks++; if (push_data1 !== 8'hA5) $display("FAIL oreg_data_c1: got %h expected a5", push_data1); else passes++;
    checks++; if (credits1 !== 3'd3) $display("FAIL oreg_credits_c1: got %0d expected 3", credits1); else passes++;
    checks++; if (idle1 !== 1'b0) $display("FAIL oreg_idle_c1: got %b expected 0", idle1); else passes++;
    cycle(); #1;
    checks++; if (push1 !== 1'b0) $display("FAIL oreg_push_c2: got %b expected 0", push1); else passes++;
    checks++; if (credits1 !== 3'd4) $display("FAIL oreg_credits_c2: got %0d expected 4", credits1); else passes++;
    checks++; if (idle1 !== 1'b1) $display("FAIL oreg_idle_c2: got %b expected 1", idle1); else passes++;
    checks++; if (in_ready1 !== 1'b0) $display("FAIL oreg_in_ready_rst: got %b expected 0", in_ready1); else passes++;
    checks++; if (err1 !== 1'b0) $display("FAIL oreg_err: got %b expected 0", err1); else passes++;
    reset1 = 1'b0; credit_in1 = 1'b0;
    cycle();
    in_valid1 = 1'b1; in_data1 = 8'h3C; #1;
    checks++; if (push1 !== 1'b0) $display("FAIL oreg_push_c3: got %b expected 0", push1); else passes++;
    cycle();
    in_valid1 = 1'b0; in_data1 = 8'h00; #1;
    checks++; if (push1 !== 1'b1) $display("FAIL oreg_push_c4: got %b expected 1", push1); else passes++;
    checks++; if (push_data1 !== 8'h3C) $display("FAIL oreg_data_c4: got %h expected 3c", push_data1); else passes++;
    checks++; if (idle1 !== 1'b0) $display("FAIL oreg_idle_c4: got %b expected 0", idle1); else passes++;
    cycle(); #1;
    checks++; if (push1 !== 1'b0) $display("FAIL oreg_push_c5: got %b expected 0", push1); else passes++;
    checks++; if (push_data1 !== 8'h3C) $display("FAIL oreg_data_hold: got %h expected 3c", push_data1); else passes++;
    checks++; if (credits1 !== 3'd3) $display("FAIL oreg_credits_c5: got %0d expected 3", credits1); else passes++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_credit_return();
    test_back_to_back();
    test_alm();
    test_err();
    test_out_reg();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
